// File: rtl/rcvr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : rcvr_pkg                                               |
// | Shared FSM encoding and a width helper for the serial receiver.  |
// | Revision: 1.0  initial parametrised receiver                     |
// +------------------------------------------------------------------+
package rcvr_pkg;

  // Receiver state: hunting for the header, or collecting payload bits.
  typedef enum logic [0:0] {
    HUNT = 1'b0,
    BODY = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sync_fifo                                              |
// | Single-clock FIFO with combinational head read and a separate    |
// | occupancy counter; push while full is accepted only with a pop.  |
// | Revision: 1.0  initial parametrised receiver                     |
// +------------------------------------------------------------------+
module sync_fifo
  import rcvr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [clog2(DEPTH):0] level
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_level == '0);
  assign full      = (r_level == c_full_level);
  // A pop frees a slot in the same cycle, so push+pop is legal even when full.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];
  assign level     = r_level;

  // Storage array; contents are don't-care after reset because level is zero.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); level tracks occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rcvr_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : rcvr_fifo                                              |
// | Serial frame receiver: sliding-window header hunt, DATA_W-bit    |
// | payload capture, words buffered in a DEPTH-entry FIFO.           |
// | Revision: 1.0  initial parametrised receiver                     |
// +------------------------------------------------------------------+
module rcvr_fifo
  import rcvr_pkg::*;
#(
  parameter int                HDR_W  = 8,
  parameter logic [HDR_W-1:0]  HDR    = 8'hA5,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  reading,
  output logic                  ready,
  output logic                  overrun,
  output logic [clog2(DEPTH):0] level,
  output logic [DATA_W-1:0]     data_out
);

  localparam int HC_W = clog2(HDR_W + 1);
  localparam int BC_W = clog2(DATA_W + 1);
  localparam logic [HC_W-1:0] c_hunt_sat  = HC_W'(HDR_W);
  localparam logic [HC_W-1:0] c_hunt_min  = HC_W'(HDR_W - 1);
  localparam logic [BC_W-1:0] c_last_bit  = BC_W'(DATA_W - 1);

  state_t              r_state;
  state_t              w_next_state;
  // Only the newest HDR_W-1 bits are kept; the live data_in completes the window.
  logic [HDR_W-2:0]    r_win;
  logic [HDR_W-1:0]    w_win_shift;
  logic [HC_W-1:0]     r_hunt_cnt;
  logic [BC_W-1:0]     r_bit_cnt;
  logic [DATA_W-1:0]   w_word;
  logic                w_match;
  logic                w_word_done;
  logic                r_overrun;
  logic                w_fifo_empty;
  logic                w_fifo_full;

  assign w_win_shift = {r_win, data_in};
  assign w_match     = (w_win_shift == HDR) && (r_hunt_cnt >= c_hunt_min);
  assign w_word_done = (r_state == BODY) && (r_bit_cnt == c_last_bit);

  // Payload shifter: the completed word includes the bit sampled this cycle.
  generate
    if (DATA_W > 1) begin : g_wide_payload
      logic [DATA_W-2:0] r_payload;
      assign w_word = {r_payload, data_in};
      // Shift payload bits only while collecting a frame body.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_payload <= '0;
        end else if (r_state == BODY) begin
          r_payload <= w_word[DATA_W-2:0];
        end
      end
    end else begin : g_single_payload
      assign w_word = data_in;
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: header match starts a body, last payload bit ends it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      HUNT:    if (w_match)     w_next_state = BODY;
      BODY:    if (w_word_done) w_next_state = HUNT;
      default: w_next_state = HUNT;
    endcase
  end

  // Header window, hunt counter and payload bit counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_win      <= '0;
      r_hunt_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state == HUNT) begin
      r_win     <= w_win_shift[HDR_W-2:0];
      r_bit_cnt <= '0;
      if (r_hunt_cnt != c_hunt_sat) begin
        r_hunt_cnt <= r_hunt_cnt + HC_W'(1);
      end
    end else begin
      r_bit_cnt <= r_bit_cnt + BC_W'(1);
      // Start the next hunt from scratch so payload bits never form a header.
      if (w_word_done) begin
        r_win      <= '0;
        r_hunt_cnt <= '0;
      end
    end
  end

  // Sticky overrun: set on a dropped word, cleared by any reading cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (reading) begin
      r_overrun <= 1'b0;
    end else if (w_word_done && w_fifo_full) begin
      r_overrun <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_word_done),
    .pop   (reading),
    .din   (w_word),
    .dout  (data_out),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .level (level)
  );

  assign ready   = !w_fifo_empty;
  assign overrun = r_overrun;

endmodule
`default_nettype wire
